instruction_fetch: RTL and testbench

Front-end stage of the single-issue RV64 core. Holds the program counter, fetches 32-bit words from instruction memory over a req/ack handshake, and presents each word with its PC to the instruction parser/register-file read stage through a valid/ready handshake. It also accepts a branch redirect from later stages and squashes any in-flight or held instruction on the wrong path.

---
 rtl/ifetch_pkg.sv | 24 ++
 rtl/pc_register.sv | 45 ++++
 rtl/instruction_fetch.sv | 139 +++++++++++++
 tb/tb_instruction_fetch.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ifetch_pkg                                                 |
// | Description : Shared widths, PC step, alignment mask and the fetch FSM   |
// |               state type for the instruction fetch stage.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package ifetch_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] PC_STEP       = 64'd4;
  // Instructions are word aligned; redirect targets lose their low two bits.
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~64'h3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage : ifetch_pkg
`default_nettype wire

// File: rtl/pc_register.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pc_register                                                |
// | Description : 64-bit program counter. Load beats increment beats hold.   |
// |               pc_next exposes the value the register takes at the next   |
// |               edge so the fetch FSM can register it as a request address.|
// | Ports       : clk, reset (async, active-low)                             |
// |               load / load_pc : redirect load (highest priority)          |
// |               inc            : advance by PC_STEP (modulo 2^64)          |
// |               pc / pc_next   : current and next PC                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pc_register
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_RESET = 64'h0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  input  logic            inc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next
);

  always_comb begin
    pc_next = pc;
    if (load) begin
      pc_next = load_pc;
    end else if (inc) begin
      pc_next = pc + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= PC_RESET;
    end else begin
      pc <= pc_next;
    end
  end

endmodule : pc_register
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : instruction_fetch                                          |
// | Description : Front-end fetch stage. Requests 32-bit words from          |
// |               instruction memory (req/ack), hands each word and its PC   |
// |               downstream (valid/ready), and squashes wrong-path work on  |
// |               a branch redirect.                                         |
// | Ports       : clk, reset (async, active-low)                             |
// |               imem_req/imem_addr/imem_ack/imem_rdata : memory side       |
// |               instruction/pc_out/instr_valid/instr_ready : parser side   |
// |               redirect/redirect_pc : taken branch from later stages      |
// |               perf_fetched/perf_stall : only with IFETCH_PERF_EN defined |
// | Options     : `define IFETCH_PERF_EN adds saturating perf counters.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module instruction_fetch
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_RESET = 64'h0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_rdata,
  output logic [ILEN-1:0] instruction,
  output logic [XLEN-1:0] pc_out,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);

  state_t          state;
  logic            squash;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic            pc_inc;

  // Only a genuine (non-squashed) return advances the PC; a redirect in the
  // same cycle still wins inside pc_register.
  assign pc_inc = (state == FETCH) && imem_ack && !squash;

  pc_register #(
    .PC_RESET (PC_RESET)
  ) u_pc (
    .clk     (clk),
    .reset   (reset),
    .load    (redirect),
    .load_pc (redirect_pc & PC_ALIGN_MASK),
    .inc     (pc_inc),
    .pc      (pc),
    .pc_next (pc_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      squash      <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= PC_RESET;
      instruction <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state     <= FETCH;
          imem_req  <= 1'b1;
          imem_addr <= pc_next;
        end

        FETCH: begin
          if (imem_ack) begin
            // Whatever happens to the data, the next request (if any) goes
            // to the PC as updated this cycle.
            imem_addr <= pc_next;
            if (squash || redirect) begin
              // Wrong-path data: drop it and issue the redirected fetch.
              squash <= 1'b0;
            end else begin
              instruction <= imem_rdata;
              pc_out      <= pc;
              instr_valid <= 1'b1;
              imem_req    <= 1'b0;
              state       <= HOLD;
            end
          end else if (redirect) begin
            // The outstanding request cannot be withdrawn; keep its address
            // stable and remember to throw its data away.
            squash <= 1'b1;
          end
        end

        HOLD: begin
          // A redirect without ready drops the held word; with ready the
          // transfer completes and downstream discards it. Both leave HOLD.
          if (instr_ready || redirect) begin
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            imem_addr   <= pc_next;
            state       <= FETCH;
          end
        end

        default: begin
          state       <= IDLE;
          squash      <= 1'b0;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (instr_valid && instr_ready && (perf_fetched != 32'hFFFF_FFFF)) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if ((state == FETCH) && imem_req && !imem_ack && (perf_stall != 32'hFFFF_FFFF)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule : instruction_fetch
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_instruction_fetch                                       |
// | Description : Randomised bench for instruction_fetch. A memory/branch    |
// |               driver pushes expected request addresses and delivered     |
// |               instructions into queues; a monitor pops and compares.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_instruction_fetch;

  localparam logic [63:0] PC_RST = 64'h1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instruction;
  logic [63:0] pc_out;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  instruction_fetch #(
    .PC_RESET (PC_RST)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .pc_out      (pc_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } item_t;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state shared between driver and monitor.
  item_t       exp_items[$];
  logic [63:0] exp_addrs[$];
  int          push_cyc = -10;
  int          drop_cyc = -10;
  bit          mon_en   = 1'b0;

  // Reference model / environment state.
  logic [63:0] model_next_pc = PC_RST;
  logic [63:0] cur_addr      = '0;
  bit          outstanding   = 1'b0;
  bit          squashed      = 1'b0;
  int          wait_cnt      = 0;
  int          lat_min = 0, lat_max = 0, rdy_pct = 100, red_pct = 0;
  bit          no_ack    = 1'b0;
  bit          force_red = 1'b0;
  logic [63:0] force_tgt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[33:2] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [63:0] pick_target();
    case ($urandom_range(0, 4))
      0:       return 64'h2003;
      1:       return 64'h3000;
      2:       return 64'hFFFF_FFFF_FFFF_FFFC;
      3:       return 64'hFFFF_FFFF_FFFF_FFF9;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},   64'(imem_req),    64'd0);
    check({tag, "_addr"},  imem_addr,        PC_RST);
    check({tag, "_instr"}, 64'(instruction), 64'd0);
    check({tag, "_pcout"}, pc_out,           64'd0);
    check({tag, "_valid"}, 64'(instr_valid), 64'd0);
`ifdef IFETCH_PERF_EN
    check({tag, "_pfetch"}, 64'(perf_fetched), 64'd0);
    check({tag, "_pstall"}, 64'(perf_stall),   64'd0);
`endif
  endtask

  // One clock of environment: memory responder, ready and redirect source.
  task automatic step(output bit hs);
    bit          do_ack, do_red, do_rdy;
    logic [63:0] tgt;
    @(negedge clk); #1;
    do_rdy    = ($urandom_range(0, 99) < rdy_pct);
    tgt       = force_red ? force_tgt : pick_target();
    do_red    = (imem_req || instr_valid) && (force_red || ($urandom_range(0, 99) < red_pct));
    force_red = 1'b0;
    do_ack    = 1'b0;
    if (imem_req) begin
      if (!outstanding) begin
        outstanding = 1'b1;
        squashed    = 1'b0;
        cur_addr    = model_next_pc;
        exp_addrs.push_back(model_next_pc);
        wait_cnt    = int'($urandom_range(lat_min, lat_max));
      end
      if (!no_ack) begin
        if (wait_cnt == 0) do_ack = 1'b1;
        else wait_cnt--;
      end
    end
    imem_ack    = do_ack;
    imem_rdata  = do_ack ? mem_word(imem_addr) : $urandom;
    instr_ready = do_rdy;
    redirect    = do_red;
    redirect_pc = tgt;
    hs          = instr_valid && do_rdy;
    if (do_red && outstanding) squashed = 1'b1;
    if (do_ack) begin
      outstanding = 1'b0;
      if (!squashed) begin
        exp_items.push_back('{pc: cur_addr, instr: mem_word(cur_addr)});
        push_cyc      = cyc;
        model_next_pc = cur_addr + 64'd4;
      end
    end
    if (do_red) begin
      if (instr_valid && !do_rdy) begin
        if (exp_items.size() > 0) void'(exp_items.pop_front());
        drop_cyc = cyc;
      end
      model_next_pc = tgt & ~64'h3;
    end
  endtask

  task automatic release_reset();
    @(negedge clk); #1;
    imem_ack      = 1'b0;
    redirect      = 1'b0;
    reset         = 1'b1;
    outstanding   = 1'b0;
    squashed      = 1'b0;
    model_next_pc = PC_RST;
    exp_items.delete();
    exp_addrs.delete();
    push_cyc      = -10;
    drop_cyc      = -10;
    mon_en        = 1'b1;
    check("idle_no_req", 64'(imem_req), 64'd0);
    @(posedge clk); #1;
    check("first_req",  64'(imem_req), 64'd1);
    check("first_addr", imem_addr,     PC_RST);
  endtask

  // Monitor: compares every request start and every completed transfer.
  initial begin
    logic        p_req = 1'b0, p_ack = 1'b0, p_valid = 1'b0, p_rdy = 1'b0, p_red = 1'b0;
    logic [63:0] p_addr = '0, p_pc = '0;
    logic [31:0] p_instr = '0;
    item_t       it;
    forever begin
      @(negedge clk); #2;
      if (!mon_en || !reset) begin
        p_req = 1'b0; p_ack = 1'b0; p_valid = 1'b0; p_rdy = 1'b0; p_red = 1'b0;
        continue;
      end
      check("req_valid_excl", 64'(imem_req && instr_valid), 64'd0);
      if (imem_req) begin
        if (p_req && !p_ack) check("addr_stable", imem_addr, p_addr);
        else if (exp_addrs.size() == 0) check("req_unexpected", 64'(imem_req), 64'd0);
        else check("req_addr", imem_addr, exp_addrs.pop_front());
      end
      if (cyc == push_cyc + 1) check("valid_after_ack", 64'(instr_valid), 64'd1);
      if (cyc == drop_cyc + 1) check("valid_dropped",   64'(instr_valid), 64'd0);
      if (instr_valid && p_valid && !p_rdy && !p_red) begin
        check("hold_instr", 64'(instruction), 64'(p_instr));
        check("hold_pc",    pc_out,           p_pc);
      end
      if (instr_valid && instr_ready) begin
        if (exp_items.size() == 0) check("xfer_unexpected", 64'(instr_valid), 64'd0);
        else begin
          it = exp_items.pop_front();
          check("pc_out",      pc_out,           it.pc);
          check("instruction", 64'(instruction), 64'(it.instr));
        end
      end
      p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
      p_valid = instr_valid; p_rdy = instr_ready; p_red = redirect;
      p_pc = pc_out; p_instr = instruction;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hs;
    bit found;
    int cnt;
    repeat (2) @(negedge clk);
    #1;
    check_reset_vals("por");
    release_reset();

    // Zero-wait memory, ready always high: one transfer every two cycles.
    lat_min = 0; lat_max = 0; rdy_pct = 100; red_pct = 0;
    cnt = 0;
    repeat (20) begin step(hs); cnt += int'(hs); end
    check("zero_wait_throughput", 64'(cnt), 64'd10);

    // Three wait states on the next request.
    lat_min = 3; lat_max = 3;
    repeat (5) step(hs);
`ifdef IFETCH_PERF_EN
    check("perf_stall_3",    64'(perf_stall),   64'd3);
    check("perf_fetched_10", 64'(perf_fetched), 64'd10);
`endif
    repeat (15) step(hs);

    // Downstream stalls while an instruction is held.
    lat_min = 0; lat_max = 2; rdy_pct = 0;
    repeat (8) step(hs);
    rdy_pct = 100;
    repeat (6) step(hs);

    // Random mix of latencies, back-pressure and redirects.
    lat_min = 0; lat_max = 3; rdy_pct = 70; red_pct = 12;
    repeat (600) step(hs);

    // Redirect to the top word so the increment wraps to zero.
    red_pct = 0; rdy_pct = 100; lat_min = 0; lat_max = 1;
    force_red = 1'b1; force_tgt = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (12) step(hs);

    // Reset in the middle of a fetch, with an ack presented during reset.
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (imem_req) begin found = 1'b1; break; end
    end
    check("mid_reset_in_fetch", 64'(found), 64'd1);
    imem_ack   = 1'b1;
    imem_rdata = $urandom;
    redirect   = 1'b0;
    mon_en     = 1'b0;
    #1 reset   = 1'b0;
    #1;
    check("async_req_drop", 64'(imem_req), 64'd0);
    check_reset_vals("mid");
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("mid_held");
    release_reset();

    lat_min = 0; lat_max = 2; rdy_pct = 80; red_pct = 5;
    repeat (30) step(hs);

    // Let the last delivered instruction drain with no further returns.
    red_pct = 0; rdy_pct = 100; no_ack = 1'b1;
    repeat (6) step(hs);
    check("drain_empty", 64'(exp_items.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_instruction_fetch
`default_nettype wire
